// File: rtl/pc_branch_pkg.sv
// rtl/pc_branch_pkg.sv - shared encodings, FSM states and counter helper for pc_branch_unit
package pc_branch_pkg;

    typedef enum logic [1:0] {
        BS_NONE = 2'b00,
        BS_COND = 2'b01,
        BS_JR   = 2'b10,
        BS_JUMP = 2'b11
    } bs_t;

    typedef enum logic [1:0] {
        SEL_SEQ = 2'b00,
        SEL_BRA = 2'b01,
        SEL_RAA = 2'b10,
        SEL_JMP = 2'b11
    } sel_t;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    localparam logic [1:0] CTR_RESET = 2'b01;

    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        if (taken) begin
            return (ctr == 2'b11) ? ctr : ctr + 2'd1;
        end
        return (ctr == 2'b00) ? ctr : ctr - 2'd1;
    endfunction

endpackage

// File: rtl/bht_counter_table.sv
// rtl/bht_counter_table.sv - 2-bit saturating branch history counters with fetch and resolve read ports
module bht_counter_table
    import pc_branch_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_msb,
    input  logic             upd_en,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken,
    output logic             upd_msb
);

    logic [1:0] ctr [DEPTH];

    assign rd_msb  = ctr[rd_idx][1];
    // Pre-update prediction of the resolving branch, used to flag a mispredict.
    assign upd_msb = ctr[upd_idx][1];

    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                ctr[i] <= CTR_RESET;
            end
        end else if (upd_en) begin
            ctr[upd_idx] <= ctr_next(ctr[upd_idx], upd_taken);
        end
    end

endmodule

// File: rtl/pc_branch_unit.sv
// rtl/pc_branch_unit.sv - program counter with branch redirect, squash FSM and BHT prediction
module pc_branch_unit
    import pc_branch_pkg::*;
#(
    parameter int PC_W         = 8,
    parameter int DATA_W       = 32,
    parameter int BHT_DEPTH    = 16,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              stall,
    input  logic [PC_W-1:0]   PC_inc,
    input  logic              br_valid,
    input  logic [PC_W-1:0]   br_pc,
    input  logic [1:0]        BS,
    input  logic              PS,
    input  logic              Z,
    input  logic [DATA_W-1:0] BrA,
    input  logic [DATA_W-1:0] RAA,
    output logic [PC_W-1:0]   PC,
    output logic              pred_taken,
    output logic              flush,
    output logic              mispredict,
    output logic              branch_predict
);

    localparam int         IDX_W      = $clog2(BHT_DEPTH);
    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

    state_t          state;
    logic [2:0]      flush_cnt;
    sel_t            sel;
    logic [PC_W-1:0] pc_next;
    logic            cond_upd;
    logic            cond_taken;
    logic            upd_msb;
    logic            unused_bits;

    // Upper target and branch-address bits are dropped; PC wraps modulo 2^PC_W.
    assign unused_bits = ^{BrA, RAA, br_pc};

    assign sel = (br_valid && state == ST_RUN)
               ? sel_t'({BS[1], ((PS ^ Z) | BS[1]) & BS[0]})
               : SEL_SEQ;
    assign branch_predict = (sel == SEL_SEQ);
    assign cond_upd       = br_valid && (state == ST_RUN) && (BS == BS_COND);
    assign cond_taken     = PS ^ Z;

    always_comb begin
        pc_next = stall ? PC : PC_inc;
        case (sel)
            SEL_BRA, SEL_JMP: pc_next = BrA[PC_W-1:0];
            SEL_RAA:          pc_next = RAA[PC_W-1:0];
            default:          pc_next = stall ? PC : PC_inc;
        endcase
    end

    bht_counter_table #(
        .DEPTH (BHT_DEPTH),
        .IDX_W (IDX_W)
    ) u_bht (
        .clk       (CLK),
        .reset     (reset),
        .rd_idx    (PC[IDX_W-1:0]),
        .rd_msb    (pred_taken),
        .upd_en    (cond_upd),
        .upd_idx   (br_pc[IDX_W-1:0]),
        .upd_taken (cond_taken),
        .upd_msb   (upd_msb)
    );

    always_ff @(negedge CLK or posedge reset) begin
        if (reset) begin
            PC         <= '0;
            state      <= ST_RUN;
            flush      <= 1'b0;
            mispredict <= 1'b0;
            flush_cnt  <= '0;
        end else begin
            PC         <= pc_next;
            mispredict <= cond_upd && (cond_taken != upd_msb);
            if (state == ST_RUN) begin
                if (sel != SEL_SEQ) begin
                    state     <= ST_FLUSH;
                    flush     <= 1'b1;
                    flush_cnt <= FLUSH_INIT;
                end
            end else if (flush_cnt == 3'd0) begin
                state <= ST_RUN;
                flush <= 1'b0;
            end else begin
                flush_cnt <= flush_cnt - 3'd1;
            end
        end
    end

endmodule
